// File: rtl/ctx_mem_pkg.sv
// rtl/ctx_mem_pkg.sv - shared widths and request entry type for the context memory bridge
package ctx_mem_pkg;

  localparam int CTX_MEM_AW = 32;
  localparam int CTX_MEM_DW = 32;

  typedef struct packed {
    logic                  we;
    logic [CTX_MEM_AW-1:0] addr;
    logic [CTX_MEM_DW-1:0] wdata;
  } ctx_mem_req_t;

endpackage

// File: rtl/ctx_mem_fifo.sv
// rtl/ctx_mem_fifo.sv - synchronous request FIFO, power-of-two depth, generic entry type
module ctx_mem_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == DEPTH_C);
  assign head_o  = mem[rd_ptr];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/ctx_mem_bridge.sv
// rtl/ctx_mem_bridge.sv - RTOS context read/write requests to OBI master; CTX_MEM_BRIDGE_PERF_EN adds grant counters
module ctx_mem_bridge
  import ctx_mem_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ctx_mem_wr_en_i,
  input  logic [CTX_MEM_AW-1:0] ctx_mem_wr_addr_i,
  input  logic [CTX_MEM_DW-1:0] ctx_mem_wr_data_i,
  input  logic                  ctx_mem_rd_rq_valid_i,
  input  logic [CTX_MEM_AW-1:0] ctx_mem_rd_rq_addr_i,
  output logic                  ctx_mem_rd_resp_valid_o,
  output logic [CTX_MEM_DW-1:0] ctx_mem_rd_data_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [CTX_MEM_AW-1:0] mem_addr_o,
  output logic [CTX_MEM_DW-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [CTX_MEM_DW-1:0] mem_rdata_i,
  output logic                  idle_o,
`ifdef CTX_MEM_BRIDGE_PERF_EN
  output logic                  overflow_o,
  output logic [31:0]           perf_wr_cnt_o,
  output logic [31:0]           perf_rd_cnt_o
`else
  output logic                  overflow_o
`endif
);

  localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

  ctx_mem_req_t push_data;
  ctx_mem_req_t head;
  logic         push_valid;
  logic         fifo_full;
  logic         fifo_empty;
  logic         grant;
  logic         rv_ok;
  logic         tag_is_read;
  logic [2:0]   outstanding;
  logic [7:0]   tag_q;
  logic [2:0]   tag_wr;
  logic [2:0]   tag_rd;

  // A read wins over a simultaneous write; the write is lost and flagged.
  always_comb begin
    push_data = '0;
    if (ctx_mem_rd_rq_valid_i) begin
      push_data.we   = 1'b0;
      push_data.addr = ctx_mem_rd_rq_addr_i;
    end else begin
      push_data.we    = 1'b1;
      push_data.addr  = ctx_mem_wr_addr_i;
      push_data.wdata = ctx_mem_wr_data_i;
    end
  end

  assign push_valid = ctx_mem_rd_rq_valid_i || ctx_mem_wr_en_i;

  ctx_mem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ctx_mem_req_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_valid),
    .push_data_i (push_data),
    .pop_i       (grant),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign mem_req_o   = !fifo_empty && (outstanding < MAX_OS);
  assign mem_we_o    = head.we;
  assign mem_addr_o  = head.addr;
  assign mem_wdata_o = head.wdata;
  assign mem_be_o    = 4'hF;

  assign grant       = mem_req_o && mem_gnt_i;
  // Stray rvalids with nothing in flight never touch the tag queue.
  assign rv_ok       = mem_rvalid_i && (outstanding != 3'd0);
  assign tag_is_read = !tag_q[tag_rd];

  assign idle_o = fifo_empty && (outstanding == 3'd0) && !ctx_mem_rd_resp_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding             <= '0;
      tag_q                   <= '0;
      tag_wr                  <= '0;
      tag_rd                  <= '0;
      ctx_mem_rd_resp_valid_o <= 1'b0;
      ctx_mem_rd_data_o       <= '0;
      overflow_o              <= 1'b0;
    end else begin
      case ({grant, rv_ok})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
      if (grant) begin
        tag_q[tag_wr] <= head.we;
        tag_wr        <= tag_wr + 3'd1;
      end
      if (rv_ok) tag_rd <= tag_rd + 3'd1;
      ctx_mem_rd_resp_valid_o <= rv_ok && tag_is_read;
      if (rv_ok && tag_is_read) ctx_mem_rd_data_o <= mem_rdata_i;
      if ((ctx_mem_rd_rq_valid_i && ctx_mem_wr_en_i) || (push_valid && fifo_full && !grant))
        overflow_o <= 1'b1;
    end
  end

`ifdef CTX_MEM_BRIDGE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_wr_cnt_o <= '0;
      perf_rd_cnt_o <= '0;
    end else if (grant) begin
      if (head.we) perf_wr_cnt_o <= perf_wr_cnt_o + 32'd1;
      else         perf_rd_cnt_o <= perf_rd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ctx_mem_bridge.md
CTX_MEM_BRIDGE -- requirements
Module: ctx_mem_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of granted memory transactions still awaiting rvalid; range 1..7.
REQ-003 SHALL have one clock, clk_i, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports ctx_mem_wr_en_i (input, 1), ctx_mem_wr_addr_i (input, 32), ctx_mem_wr_data_i (input, 32): context write request from the RTOS unit.
REQ-006 SHALL have ports ctx_mem_rd_rq_valid_i (input, 1) and ctx_mem_rd_rq_addr_i (input, 32): context read request.
REQ-007 SHALL have ports ctx_mem_rd_resp_valid_o (output, 1) and ctx_mem_rd_data_o (output, 32): read response back to the RTOS unit.
REQ-008 SHALL have ports mem_req_o (output, 1), mem_gnt_i (input, 1), mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, 32), mem_wdata_o (output, 32), mem_rvalid_i (input, 1), mem_rdata_i (input, 32): OBI master port.
REQ-009 SHALL have ports idle_o (output, 1) and overflow_o (output, 1, sticky).

Function
REQ-010 Each cycle, ctx_mem_rd_rq_valid_i pushes entry {we=0, addr}, else ctx_mem_wr_en_i pushes {we=1, addr, data}.
REQ-011 When both request inputs are high in one cycle, only the read SHALL be pushed, the write dropped and overflow_o set.
REQ-012 A push when the FIFO is full without a same-cycle pop SHALL be dropped and set overflow_o; a push when full with a same-cycle pop SHALL be accepted.
REQ-013 mem_req_o SHALL equal FIFO non-empty AND outstanding < MAX_OUTSTANDING.
REQ-014 mem_we_o, mem_addr_o and mem_wdata_o SHALL come from the FIFO head; mem_be_o SHALL be 4'hF.
REQ-015 Request outputs SHALL hold stable while mem_req_o is high and mem_gnt_i is low.
REQ-016 mem_req_o && mem_gnt_i SHALL pop the head, increment outstanding, and push its we bit into an in-order tag queue.
REQ-017 mem_rvalid_i SHALL decrement outstanding and pop the tag queue.
REQ-018 When grant and rvalid coincide, outstanding SHALL remain unchanged.
REQ-019 If the popped tag is a read, ctx_mem_rd_resp_valid_o SHALL pulse exactly 1 cycle after mem_rvalid_i, with ctx_mem_rd_data_o = the registered mem_rdata_i; write rvalids SHALL produce no response.
REQ-020 mem_rvalid_i while outstanding == 0 SHALL be ignored.
REQ-021 idle_o SHALL equal FIFO empty AND outstanding == 0 AND no response pending.
REQ-022 Minimum latency from read request to response SHALL be 3 cycles (push, grant with 0-wait gnt and rvalid next cycle, registered response).
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 On rst_ni low: FIFO and tag queue empty, outstanding = 0, mem_req_o = 0, ctx_mem_rd_resp_valid_o = 0, ctx_mem_rd_data_o = 0, overflow_o = 0, idle_o = 1.
REQ-025 Reset mid-transaction SHALL discard all pending entries; rvalids arriving afterwards SHALL be ignored per REQ-020.

Configuration
REQ-026 With CTX_MEM_BRIDGE_PERF_EN defined, the block SHALL add outputs perf_wr_cnt_o and perf_rd_cnt_o (32 bits each), counting granted writes and reads, wrapping at 2^32, and reset to 0.
REQ-027 Without CTX_MEM_BRIDGE_PERF_EN, those ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-028 Package ctx_mem_pkg SHALL hold CTX_MEM_AW = 32, CTX_MEM_DW = 32, and typedef ctx_mem_req_t {we, addr, wdata}.
REQ-029 The request FIFO SHALL be the sub-module ctx_mem_fifo (synchronous, parameterised depth and type); the tag queue SHALL be inline.

Verification
REQ-030 Write 0x100 <- 0xDEADBEEF with 0-wait gnt -> mem_we_o = 1, addr 0x100, wdata 0xDEADBEEF, be 0xF; no rd_resp pulse.
REQ-031 Read 0x104 with gnt delayed 3 cycles and rvalid data 0x12345678 -> request held stable; rd_resp_valid 1 cycle after rvalid with data 0x12345678.
REQ-032 5 back-to-back writes with gnt held low, FIFO_DEPTH = 4 -> 4 accepted, 5th dropped, overflow_o = 1 until reset.
REQ-033 Interleaved W, R, W, R with MAX_OUTSTANDING = 2 and rvalid lag of 2 -> at most 2 outstanding, exactly 2 responses in issue order.
REQ-034 Read and write asserted in the same cycle -> only the read issued; overflow_o = 1.
REQ-035 Reset asserted with 2 outstanding, then a stray rvalid -> no response; idle_o = 1 and overflow_o = 0.
